uart_receive: RTL and testbench

- 8-bit asynchronous serial receiver: 8N1 by default, optional parity. Counterpart of the team's UART transmitter; shares its MAINCLOCK/BAUDRATE parameter scheme.
- Synchronizes the asynchronous rx line, validates the start bit, and majority-samples each bit at mid-period.
- Delivers each byte with a one-cycle done strobe plus framing/parity status.
- Sits beside the transmitter in the 50 MHz PLL domain; feeds command/loopback logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_receive.sv | 143 ++++++++++++++
 tb/tb_uart_receive.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes, baud divisor.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int clks_per_bit(input int mainclock, input int baudrate);
        return mainclock / baudrate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line.
// Resets to the idle-high level so no false start appears out of reset.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic i_rx,
    output logic o_rx_s
);

    logic [1:0] r_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    assign o_rx_s = r_sync[1];

endmodule

// File: rtl/uart_receive.sv
// 8-bit UART receiver with optional parity.
// Three-sample majority vote around mid-bit; one-cycle done strobe.
module uart_receive
    import uart_pkg::*;
#(
    parameter int MAINCLOCK = 50000000,
    parameter int BAUDRATE  = 115200,
    parameter int PARITY    = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_rx,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam int CPB  = clks_per_bit(MAINCLOCK, BAUDRATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_S2   = CW'(HALF + 1);

    if (CPB < 8) begin : g_cpb_check
        $error("uart_receive: MAINCLOCK/BAUDRATE must be >= 8");
    end

    uart_state_t   r_state;
    uart_state_t   w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic          r_s0;
    logic          r_s1;
    logic [7:0]    r_shift;
    logic          r_pbit;
    logic          r_done;
    logic [7:0]    r_data;
    logic          r_ferr;
    logic          r_perr;

    logic w_rx_s;
    logic w_maj;
    logic w_mid;
    logic w_end;
    logic w_perr;

    uart_rx_sync u_sync (
        .clock  (clock),
        .reset  (reset),
        .i_rx   (i_rx),
        .o_rx_s (w_rx_s)
    );

    assign w_maj = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    assign w_mid = (r_cnt == C_S2);
    assign w_end = (r_cnt == C_LAST);

    // Odd parity wants the 9-bit xor to be 1, even wants 0.
    assign w_perr = (PARITY != PARITY_NONE) &&
                    ((^r_shift ^ r_pbit) != (PARITY == PARITY_ODD));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) w_next = S_START;
            end
            S_START: begin
                if (w_mid && w_maj) w_next = S_IDLE;
                else if (w_end)     w_next = S_DATA;
            end
            S_DATA: begin
                if (w_end && r_bit == 3'd7) begin
                    w_next = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_end) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_mid) w_next = w_maj ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (w_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
            r_shift <= '0;
            r_pbit  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if (r_state == S_IDLE || r_state == S_BREAK || w_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_cnt == C_S0) r_s0 <= w_rx_s;
            if (r_cnt == C_S1) r_s1 <= w_rx_s;
            if (r_state == S_DATA && w_mid) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
            if (r_state == S_DATA && w_end) begin
                r_bit <= r_bit + 3'd1;
            end
            if (r_state == S_PARITY && w_mid) begin
                r_pbit <= w_maj;
            end
            // Publish at the stop decision; do not wait for the stop bit end.
            if (r_state == S_STOP && w_mid) begin
                r_done <= 1'b1;
                r_data <= r_shift;
                r_ferr <= ~w_maj;
                r_perr <= w_perr;
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE) && (r_state != S_BREAK);
    assign o_done       = r_done;
    assign o_data       = r_data;
    assign o_frame_err  = r_ferr;
    assign o_parity_err = r_perr;

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: three instances (8N1 16 clk/bit, even parity
// 16 clk/bit, default 434 clk/bit) checked against a scoreboard.
module tb_uart_receive;

    localparam int P = 10;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       pbit;
        logic       stopv;
        int         gbit;
        bit         bchk;
        int         gap;
        logic [7:0] e_data;
        logic       e_fe;
        logic       e_pe;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] rx    = 3'b111;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] fe;
    logic [2:0] pe;
    logic [7:0] dat [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   ndone [3] = '{0, 0, 0};
    time  t_stop [3];
    int   n_chk  = 0;
    int   n_pass = 0;

    exp_t m_e;
    bit   m_have;
    int   m_lat;

    always #(P / 2) clock = ~clock;

    uart_receive #(.MAINCLOCK(16), .BAUDRATE(1), .PARITY(0)) u0 (
        .clock(clock), .reset(reset), .i_rx(rx[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_data(dat[0]),
        .o_frame_err(fe[0]), .o_parity_err(pe[0])
    );

    uart_receive #(.MAINCLOCK(16), .BAUDRATE(1), .PARITY(2)) u1 (
        .clock(clock), .reset(reset), .i_rx(rx[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_data(dat[1]),
        .o_frame_err(fe[1]), .o_parity_err(pe[1])
    );

    uart_receive u2 (
        .clock(clock), .reset(reset), .i_rx(rx[2]),
        .o_busy(busy[2]), .o_done(done[2]), .o_data(dat[2]),
        .o_frame_err(fe[2]), .o_parity_err(pe[2])
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d]) begin
                ndone[d]++;
                m_have = 1'b0;
                case (d)
                    0: if (q0.size() != 0) begin m_e = q0.pop_front(); m_have = 1'b1; end
                    1: if (q1.size() != 0) begin m_e = q1.pop_front(); m_have = 1'b1; end
                    default: if (q2.size() != 0) begin m_e = q2.pop_front(); m_have = 1'b1; end
                endcase
                chk($sformatf("done_expected_u%0d", d), 32'(m_have), 32'd1);
                if (m_have) begin
                    chk($sformatf("data_u%0d", d), 32'(dat[d]), 32'(m_e.d));
                    chk($sformatf("frame_err_u%0d", d), 32'(fe[d]), 32'(m_e.fe));
                    chk($sformatf("parity_err_u%0d", d), 32'(pe[d]), 32'(m_e.pe));
                    if (d == 2) begin
                        // Cycles counted from the edge that first samples the stop bit.
                        m_lat = int'(($time - t_stop[2]) / P) - 1;
                        n_chk++;
                        if (m_lat >= 219 && m_lat <= 221) n_pass++;
                        else $display("FAIL latency_u2: got %0d expected 220+-1", m_lat);
                    end
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int   cn;
        int   h;
        int   nb;
        logic fr [11];
        exp_t e;
        cn = (v.dut == 2) ? 434 : 16;
        h  = cn / 2;
        nb = (v.dut == 1) ? 11 : 10;
        e  = '{v.e_data, v.e_fe, v.e_pe};
        case (v.dut)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i + 1] = v.data[i];
        fr[9]      = v.pbit;
        fr[nb - 1] = v.stopv;
        for (int k = 0; k < nb; k++) begin
            if (k == nb - 1) t_stop[v.dut] = $time;
            for (int c = 0; c < cn; c++) begin
                rx[v.dut] = (k == v.gbit && c == h + 1) ? ~fr[k] : fr[k];
                if (v.bchk && c == h && k < nb - 1)
                    chk($sformatf("busy_bit%0d", k), 32'(busy[v.dut]), 32'd1);
                @(negedge clock);
            end
        end
        rx[v.dut] = 1'b1;
        repeat (v.gap) @(negedge clock);
    endtask

    vec_t tbl [9];
    vec_t v;
    int   base;

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, -1, 1'b1, 32,  8'hA5, 1'b0, 1'b0};
        tbl[1] = '{0, 8'h00, 1'b0, 1'b1, -1, 1'b0, 0,   8'h00, 1'b0, 1'b0};
        tbl[2] = '{0, 8'hFF, 1'b0, 1'b1, -1, 1'b0, 0,   8'hFF, 1'b0, 1'b0};
        tbl[3] = '{0, 8'h3C, 1'b0, 1'b1, -1, 1'b0, 32,  8'h3C, 1'b0, 1'b0};
        tbl[4] = '{0, 8'h00, 1'b0, 1'b1, 4,  1'b0, 32,  8'h00, 1'b0, 1'b0};
        tbl[5] = '{1, 8'h07, 1'b0, 1'b1, -1, 1'b0, 32,  8'h07, 1'b0, 1'b1};
        tbl[6] = '{1, 8'h07, 1'b1, 1'b1, -1, 1'b0, 32,  8'h07, 1'b0, 1'b0};
        tbl[7] = '{1, 8'h03, 1'b0, 1'b1, -1, 1'b0, 32,  8'h03, 1'b0, 1'b0};
        tbl[8] = '{2, 8'h4B, 1'b0, 1'b1, -1, 1'b1, 100, 8'h4B, 1'b0, 1'b0};

        repeat (3) @(negedge clock);
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset_outputs_u%0d", d),
                32'({busy[d], done[d], dat[d], fe[d], pe[d]}), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        foreach (tbl[i]) send(tbl[i]);
        chk("done_count_u0", 32'(ndone[0]), 32'd5);
        chk("done_count_u1", 32'(ndone[1]), 32'd3);
        chk("done_count_u2", 32'(ndone[2]), 32'd1);

        // Start glitch: four low clocks only.
        base = ndone[0];
        rx[0] = 1'b0;
        repeat (4) @(negedge clock);
        rx[0] = 1'b1;
        chk("glitch_busy_rise", 32'(busy[0]), 32'd1);
        repeat (9) @(negedge clock);
        chk("glitch_busy_fall", 32'(busy[0]), 32'd0);
        repeat (32) @(negedge clock);
        chk("glitch_no_done", 32'(ndone[0]), 32'(base));

        // Stop bit low, then line held low for 40 bit periods.
        base = ndone[0];
        v = '{0, 8'h00, 1'b0, 1'b0, -1, 1'b0, 0, 8'h00, 1'b1, 1'b0};
        send(v);
        rx[0] = 1'b0;
        repeat (640) @(negedge clock);
        chk("break_busy", 32'(busy[0]), 32'd0);
        rx[0] = 1'b1;
        repeat (48) @(negedge clock);
        chk("break_single_done", 32'(ndone[0]), 32'(base + 1));
        v = '{0, 8'h55, 1'b0, 1'b1, -1, 1'b0, 32, 8'h55, 1'b0, 1'b0};
        send(v);

        // Reset during data bit 4 of 0x81.
        base = ndone[0];
        rx[0] = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx[0] = (i == 0);
            repeat (16) @(negedge clock);
        end
        rx[0] = 1'b0;
        repeat (8) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        chk("midreset_u0", 32'({busy[0], done[0], dat[0], fe[0], pe[0]}), 32'd0);
        chk("midreset_u1", 32'({busy[1], done[1], dat[1], fe[1], pe[1]}), 32'd0);
        @(negedge clock);
        rx[0] = 1'b1;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        repeat (32) @(negedge clock);
        chk("midreset_no_done", 32'(ndone[0]), 32'(base));
        v = '{0, 8'h81, 1'b0, 1'b1, -1, 1'b0, 32, 8'h81, 1'b0, 1'b0};
        send(v);

        chk("sb_empty_u0", 32'(q0.size()), 32'd0);
        chk("sb_empty_u1", 32'(q1.size()), 32'd0);
        chk("sb_empty_u2", 32'(q2.size()), 32'd0);
        chk("final_done_u0", 32'(ndone[0]), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
